tmiv_hssaer_enc: RTL
====================

TMIV_HSSAER_ENC -- requirements
Module: tmiv_hssaer_enc

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all logic.
REQ-002 SHALL have port _rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port en  input  1  transmit enable; low blocks new acceptances.
REQ-004 SHALL have port tvt_d  input  3  symbol to send; valid codes 0..4.
REQ-005 SHALL have port tvt_st  input  1  symbol valid strobe.
REQ-006 SHALL have port tvt_rdy  output  1  encoder can accept a symbol this cycle.
REQ-007 SHALL have port tvt_err  output  1  one-cycle pulse on a rejected symbol.
REQ-008 SHALL have port hs_tx  output  1  transition-coded serial line.
REQ-009 SHALL have port busy  output  1  an interval is in progress.

Function
REQ-010 SHALL encode each symbol s as the interval between consecutive hs_tx toggles: L(s) = 3*(s+1) cycles, i.e. 3/6/9/12/15 for s = 0..4, the centre of each receiver decode bin.
REQ-011 SHALL transfer a symbol on a rising edge where tvt_st && tvt_rdy; no transfer otherwise.
REQ-012 SHALL drive tvt_rdy combinationally = en && (state==IDLE || (state==RUN && cnt==1)).
REQ-013 SHALL implement states IDLE and RUN, with a 4-bit down-counter cnt.
REQ-014 IDLE: hs_tx holds its level; busy=0; on transfer, cnt<=L(s), go to RUN.
REQ-015 RUN: busy=1; each edge with cnt>1, cnt<=cnt-1.
REQ-016 RUN, edge with cnt==1: hs_tx inverts.
REQ-017 RUN, edge with cnt==1 and a transfer: cnt<=L(new) and stay in RUN, so back-to-back symbols produce gap-free intervals.
REQ-018 RUN, edge with cnt==1 and no transfer: go to IDLE.
REQ-019 The first toggle after an IDLE transfer SHALL occur exactly L(s) edges after the transfer edge.
REQ-020 en deasserted during RUN SHALL let the current interval complete, including its toggle, then enter IDLE.
REQ-021 tvt_d SHALL be sampled only on transfer edges; changes at other times have no effect.
REQ-022 tvt_err SHALL be low except as defined in REQ-025.

Reset
REQ-023 While _rst is low: state=IDLE, cnt=0, hs_tx=0, tvt_err=0, busy=0; tvt_rdy follows en.
REQ-024 Reset asserted mid-interval SHALL abort the interval with no toggle; the first symbol after release follows REQ-019.

Configuration
REQ-025 With TMIV_HSSAER_ENC_SYMCHK_EN defined, codes 5..7:
- are still transferred (consumed);
- start no interval; state unchanged;
- raise tvt_err for exactly one cycle after the transfer edge.
A rejected code on a cnt==1 edge SHALL let the toggle happen and the FSM go to IDLE.
REQ-026 Without TMIV_HSSAER_ENC_SYMCHK_EN, codes 5..7 SHALL be clamped to symbol 4 (15 cycles) and tvt_err SHALL be tied low.

Structure
REQ-027 Package tmiv_hssaer_pkg SHALL hold:
- TMIV_UNIT=3;
- TMIV_SYM_MAX=4;
- TMIV_CNT_W=4;
- the symbol-to-interval lookup function;
- the state enumeration.
The receiver decoder SHALL reuse these constants.
REQ-028 No sub-module: the FSM and counter live in one module.

Verification
REQ-029 Reset, en=1, transfer s=2 → hs_tx 0→1 exactly 9 edges after the transfer edge; busy high for those 9 cycles.
REQ-030 Back-to-back s=0,4,1 with tvt_st held high → toggles separated by 3, 15, 6 cycles; tvt_rdy high only on IDLE and cnt==1 cycles.
REQ-031 en dropped 2 cycles into s=3 → toggle still at 12 cycles; no further transfer; FSM returns to IDLE.
REQ-032 _rst pulsed low 5 cycles into s=4 → hs_tx=0 immediately, no toggle, busy=0; next s=0 toggles 3 cycles after its transfer.
REQ-033 With SYMCHK_EN, send s=6 → tvt_err one-cycle pulse, no toggle; without SYMCHK_EN → toggle after 15 cycles, tvt_err stays 0.
REQ-034 Loopback into the TMIV measurement block and receiver decoder, 1000 random symbols 0..4 → decoded sequence matches with zero errors.

Source files
------------

// File: rtl/tmiv_hssaer_enc_pkg.sv
// Shared TMIV constants, symbol-to-interval lookup and encoder state type.
// The receiver-side decoder uses the same constants so both ends agree on bin centres.
package tmiv_hssaer_pkg;

  localparam int unsigned TMIV_UNIT    = 3;
  localparam int unsigned TMIV_SYM_MAX = 4;
  localparam int unsigned TMIV_CNT_W   = 4;

  typedef enum logic {
    IDLE,
    RUN
  } tmiv_state_t;

  // Interval length in cycles for a symbol; codes above the maximum map to the maximum.
  function automatic logic [TMIV_CNT_W-1:0] tmiv_sym_len(input logic [2:0] sym);
    int unsigned s;
    if (sym > 3'(TMIV_SYM_MAX)) s = TMIV_SYM_MAX;
    else                        s = 32'(sym);
    return TMIV_CNT_W'(TMIV_UNIT * (s + 1));
  endfunction

endpackage

// File: rtl/tmiv_hssaer_enc_if.sv
// Symbol handshake between a symbol source (master) and the TMIV encoder (slave).
interface tmiv_hssaer_enc_if;
  logic [2:0] tvt_d;
  logic       tvt_st;
  logic       tvt_rdy;
  logic       tvt_err;

  modport master (output tvt_d, output tvt_st, input tvt_rdy, input tvt_err);
  modport slave  (input tvt_d, input tvt_st, output tvt_rdy, output tvt_err);
endinterface

// File: rtl/tmiv_hssaer_enc.sv
// TMIV HSSAER transmitter: each symbol becomes the interval between two
// consecutive hs_tx toggles, 3*(s+1) cycles long. Back-to-back symbols
// reload on the toggle edge so intervals are gap-free.
// Optional macro TMIV_HSSAER_ENC_SYMCHK_EN: reject codes 5..7 with a
// one-cycle tvt_err pulse instead of clamping them to symbol 4.
module tmiv_hssaer_enc
  import tmiv_hssaer_pkg::*;
(
  input  logic                    clk,
  input  logic                    _rst,
  input  logic                    en,
  tmiv_hssaer_enc_if.slave        tvt,
  output logic                    hs_tx,
  output logic                    busy
);

  tmiv_state_t           state, state_n;
  logic [TMIV_CNT_W-1:0] cnt, cnt_n;
  logic                  hs_n;
  logic                  cnt_last;
  logic                  xfer;
  logic                  sym_ok;

  assign cnt_last    = (cnt == TMIV_CNT_W'(1));
  assign tvt.tvt_rdy = en && ((state == IDLE) || ((state == RUN) && cnt_last));
  assign xfer        = tvt.tvt_st && tvt.tvt_rdy;
  assign busy        = (state == RUN);

`ifdef TMIV_HSSAER_ENC_SYMCHK_EN
  logic err_q;

  assign sym_ok      = (tvt.tvt_d <= 3'(TMIV_SYM_MAX));
  assign tvt.tvt_err = err_q;

  // Rejected code pulse: high for the cycle following its transfer edge.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) err_q <= 1'b0;
    else       err_q <= xfer && !sym_ok;
  end
`else
  assign sym_ok      = 1'b1;
  assign tvt.tvt_err = 1'b0;
`endif

  // Next-state: count down the interval, toggle on its last cycle, reload or idle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hs_n    = hs_tx;
    unique case (state)
      IDLE: begin
        if (xfer && sym_ok) begin
          cnt_n   = tmiv_sym_len(tvt.tvt_d);
          state_n = RUN;
        end
      end
      RUN: begin
        if (cnt > TMIV_CNT_W'(1)) begin
          cnt_n = cnt - TMIV_CNT_W'(1);
        end else begin
          hs_n = ~hs_tx;
          if (xfer && sym_ok) begin
            cnt_n = tmiv_sym_len(tvt.tvt_d);
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // State, counter and line register; reset aborts any interval without toggling.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state <= IDLE;
      cnt   <= '0;
      hs_tx <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hs_tx <= hs_n;
    end
  end

endmodule
